// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with bypass, hardwired zero, scoreboard and debug port
//
// Purpose: general-purpose register file for the pipelined MIPS core. It has
// one clocked write port (WB), two combinational read ports (ID) and a
// pending-write scoreboard that lets ID detect RAW hazards. It also has a
// debug read port that does not bypass.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   we, waddr, wdata    write-back port; the write lands on the rising edge
//   raddr1/2, rdata1/2  combinational operand reads, with optional bypass
//   issue, issue_addr   marks issue_addr as having an outstanding producer
//   busy1/2             the register read on port 1/2 is still pending
//   dbg_addr, dbg_data  debug read of the stored value (zero rule, no bypass)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int   DEPTH     = 2 ** ADDR_W;
  localparam logic ZERO_EN   = (ZERO_REG != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic wr_en;
  logic iss_en;
  logic hit1, hit2;
  logic zero1, zero2, zero_dbg;

  // With the hardwired zero, index 0 never stores data and never goes busy.
  assign wr_en  = we && !(ZERO_EN && (waddr == '0));
  assign iss_en = issue && !(ZERO_EN && (issue_addr == '0));

  // The retiring write clears its bit first, so an issue to the same index
  // in the same cycle wins: the new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy;
    if (we) busy_next[waddr] = 1'b0;
    if (iss_en) busy_next[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en) regs[waddr] <= wdata;
      busy <= busy_next;
    end
  end

  assign zero1    = ZERO_EN && (raddr1 == '0);
  assign zero2    = ZERO_EN && (raddr2 == '0);
  assign zero_dbg = ZERO_EN && (dbg_addr == '0);
  assign hit1     = BYPASS_EN && we && (waddr == raddr1);
  assign hit2     = BYPASS_EN && we && (waddr == raddr2);

  always_comb begin
    rdata1 = regs[raddr1];
    if (zero1)     rdata1 = '0;
    else if (hit1) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (zero2)     rdata2 = '0;
    else if (hit2) rdata2 = wdata;
  end

  // A forwarded retiring write means the operand is already available.
  assign busy1 = busy[raddr1] && !hit1 && !zero1;
  assign busy2 = busy[raddr2] && !hit2 && !zero2;

  assign dbg_data = zero_dbg ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb in two configurations
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, we, issue;
  logic [4:0]  waddr, raddr1, raddr2, issue_addr, dbg_addr;
  logic [31:0] wdata;

  // u_a: ZERO_REG=1, BYPASS=1. u_b: ZERO_REG=0, BYPASS=0.
  logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
  logic        by1_a, by2_a, by1_b, by2_b;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: stored values and pending flags for each configuration.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic        ba [32];
  logic        bb [32];

  always #5 clk = ~clk;

  regfile_sb u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
    .issue(issue), .issue_addr(issue_addr), .busy1(by1_a), .busy2(by2_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
    .issue(issue), .issue_addr(issue_addr), .busy1(by1_b), .busy2(by2_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  // Expected combinational outputs, derived from the current inputs and model.
  function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return ma[a];
  endfunction

  function automatic logic exp_busy_a(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return ba[a] && !(we && waddr == a);
  endfunction

  function automatic logic [31:0] exp_dbg_a(input logic [4:0] a);
    return (a == 0) ? 32'h0 : ma[a];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 0; mb[i] = 0; ba[i] = 0; bb[i] = 0;
      end
    end else begin
      if (we) begin
        if (waddr != 0) ma[waddr] = wdata;
        mb[waddr] = wdata;
        ba[waddr] = 1'b0;
        bb[waddr] = 1'b0;
      end
      if (issue) begin
        if (issue_addr != 0) ba[issue_addr] = 1'b1;
        bb[issue_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; we = 0; issue = 0; waddr = 0; wdata = 0;
    raddr1 = 0; raddr2 = 0; issue_addr = 0; dbg_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < 32; i++) begin
      we = 1; waddr = i[4:0]; wdata = 32'hFFFF_FFFF;
      issue = 1; issue_addr = 5'(31 - i);
      tick();
    end
    idle();
    reset = 1;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; raddr1 = i[4:0]; raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (dbg_a !== 32'h0 || dbg_b !== 32'h0) begin
        errors++;
        $display("FAIL reset_dbg idx %0d got a=%h b=%h exp 0", i, dbg_a, dbg_b);
      end
      checks++;
      if ({by1_a, by2_a, by1_b, by2_b} !== 4'b0) begin
        errors++;
        $display("FAIL reset_busy idx %0d got %b exp 0000", i, {by1_a, by2_a, by1_b, by2_b});
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1; waddr = 8; wdata = 32'h1234_5678; raddr1 = 8; dbg_addr = 8;
    #1;
    checks++;
    if (rd1_a !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_same_cycle got %h exp 12345678", rd1_a);
    end
    checks++;
    if (rd1_b !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle got %h exp 0", rd1_b);
    end
    checks++;
    if (dbg_a !== 32'h0 || dbg_b !== 32'h0) begin
      errors++; $display("FAIL dbg_no_bypass got a=%h b=%h exp 0", dbg_a, dbg_b);
    end
    tick();
    we = 0;
    #1;
    checks++;
    if (rd1_a !== 32'h1234_5678 || rd1_b !== 32'h1234_5678) begin
      errors++; $display("FAIL write_visible got a=%h b=%h exp 12345678", rd1_a, rd1_b);
    end
    checks++;
    if (dbg_a !== 32'h1234_5678 || dbg_b !== 32'h1234_5678) begin
      errors++; $display("FAIL dbg_after_write got a=%h b=%h exp 12345678", dbg_a, dbg_b);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1; waddr = 0; wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    issue = 1; issue_addr = 0;
    #1;
    checks++;
    if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
      errors++; $display("FAIL zero_read got %h/%h exp 0", rd1_a, rd2_a);
    end
    checks++;
    if (rd1_b !== 32'hDEAD_BEEF || dbg_b !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reg0_plain got %h/%h exp deadbeef", rd1_b, dbg_b);
    end
    tick();
    issue = 0;
    #1;
    checks++;
    if (by1_a !== 1'b0 || by2_a !== 1'b0) begin
      errors++; $display("FAIL zero_busy got %b%b exp 00", by1_a, by2_a);
    end
    checks++;
    if (by1_b !== 1'b1) begin
      errors++; $display("FAIL reg0_plain_busy got %b exp 1", by1_b);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue = 1; issue_addr = 9; raddr1 = 9;
    tick();
    issue = 0;
    #1;
    checks++;
    if (by1_a !== 1'b1 || by1_b !== 1'b1) begin
      errors++; $display("FAIL busy_after_issue got a=%b b=%b exp 1", by1_a, by1_b);
    end
    we = 1; waddr = 9; wdata = 32'h55;
    #1;
    checks++;
    if (by1_a !== 1'b0 || rd1_a !== 32'h55) begin
      errors++; $display("FAIL writeback_bypass got busy=%b data=%h exp 0/55", by1_a, rd1_a);
    end
    checks++;
    if (by1_b !== 1'b1 || rd1_b !== 32'h0) begin
      errors++; $display("FAIL writeback_nobypass got busy=%b data=%h exp 1/0", by1_b, rd1_b);
    end
    tick();
    we = 0;
    #1;
    checks++;
    if (by1_a !== 1'b0 || by1_b !== 1'b0 || rd1_a !== 32'h55 || rd1_b !== 32'h55) begin
      errors++;
      $display("FAIL after_writeback got busy=%b%b data=%h/%h exp 00 55", by1_a, by1_b, rd1_a, rd1_b);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    d = $urandom;
    idle();
    issue = 1; issue_addr = 10; we = 1; waddr = 10; wdata = d;
    tick();
    idle();
    raddr1 = 10; dbg_addr = 10;
    #1;
    checks++;
    if (by1_a !== 1'b1 || by1_b !== 1'b1) begin
      errors++; $display("FAIL set_wins_busy got a=%b b=%b exp 1", by1_a, by1_b);
    end
    checks++;
    if (dbg_a !== d || dbg_b !== d) begin
      errors++; $display("FAIL set_wins_data got a=%h b=%h exp %h", dbg_a, dbg_b, d);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 3; i <= 5; i++) begin
      issue = 1; issue_addr = i[4:0];
      tick();
    end
    idle();
    reset = 1; we = 1; waddr = 3; wdata = 32'hA5A5_A5A5; issue = 1; issue_addr = 7;
    tick();
    idle();
    dbg_addr = 3;
    for (int i = 3; i <= 7; i++) begin
      raddr1 = i[4:0]; raddr2 = i[4:0];
      #1;
      checks++;
      if ({by1_a, by2_a, by1_b, by2_b} !== 4'b0) begin
        errors++;
        $display("FAIL reset_mid_busy idx %0d got %b exp 0000", i, {by1_a, by2_a, by1_b, by2_b});
      end
    end
    checks++;
    if (dbg_a !== 32'h0 || dbg_b !== 32'h0) begin
      errors++; $display("FAIL reset_mid_write got a=%h b=%h exp 0", dbg_a, dbg_b);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      // Narrow address range most of the time so collisions are frequent.
      reset      = ($urandom_range(0, 49) == 0);
      we         = $urandom_range(0, 1);
      issue      = $urandom_range(0, 2) != 0;
      waddr      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      issue_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      raddr1     = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 5));
      raddr2     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      dbg_addr   = $urandom_range(0, 5);
      wdata      = $urandom;
      #1;
      checks++;
      if (rd1_a !== exp_rd_a(raddr1) || rd2_a !== exp_rd_a(raddr2)) begin
        errors++;
        $display("FAIL rand_rdata_a cyc %0d got %h/%h exp %h/%h", n, rd1_a, rd2_a,
                 exp_rd_a(raddr1), exp_rd_a(raddr2));
      end
      checks++;
      if (by1_a !== exp_busy_a(raddr1) || by2_a !== exp_busy_a(raddr2)) begin
        errors++;
        $display("FAIL rand_busy_a cyc %0d got %b%b exp %b%b", n, by1_a, by2_a,
                 exp_busy_a(raddr1), exp_busy_a(raddr2));
      end
      checks++;
      if (rd1_b !== mb[raddr1] || rd2_b !== mb[raddr2]) begin
        errors++;
        $display("FAIL rand_rdata_b cyc %0d got %h/%h exp %h/%h", n, rd1_b, rd2_b,
                 mb[raddr1], mb[raddr2]);
      end
      checks++;
      if (by1_b !== bb[raddr1] || by2_b !== bb[raddr2]) begin
        errors++;
        $display("FAIL rand_busy_b cyc %0d got %b%b exp %b%b", n, by1_b, by2_b, bb[raddr1], bb[raddr2]);
      end
      checks++;
      if (dbg_a !== exp_dbg_a(dbg_addr) || dbg_b !== mb[dbg_addr]) begin
        errors++;
        $display("FAIL rand_dbg cyc %0d got %h/%h exp %h/%h", n, dbg_a, dbg_b,
                 exp_dbg_a(dbg_addr), mb[dbg_addr]);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      ma[i] = 'x; mb[i] = 'x; ba[i] = 1'bx; bb[i] = 1'bx;
    end
    #1;
    tick();
    tick();
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
